// File: rtl/phase_corrector_pkg.sv
// Shared types and defaults for the phase corrector scheduler.
// Tags travel beside each datapath sample to route results home.
package phase_corrector_pkg;

    localparam int NB_DATA_DEF    = 16;
    localparam int N_CH_DEF       = 4;
    localparam int DP_LATENCY_DEF = 2;
    localparam int MAX_CH         = 8;
    localparam int CH_W           = 3;

    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
    } tag_t;

    function automatic logic [MAX_CH-1:0] ch_onehot(
        input logic [CH_W-1:0] idx
    );
        logic [MAX_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/phase_corrector_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; search starts one past the pointer.
// The pointer register is owned by the parent.
module rr_arbiter
    import phase_corrector_pkg::*;
#(
    parameter  int N_CH  = N_CH_DEF,
    localparam int NB_CH = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [NB_CH-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [NB_CH-1:0] win_o,
    output logic             any_o
);

    logic [NB_CH-1:0] idx;

    // Walk from the farthest candidate back to the nearest so the
    // nearest requester after the pointer overwrites the others.
    always_comb begin
        win_o = ptr_i;
        any_o = 1'b0;
        idx   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = NB_CH'((int'(ptr_i) + k) % N_CH);
            if (req_i[idx]) begin
                win_o = idx;
                any_o = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int c = 0; c < N_CH; c++) begin
            gnt_o[c] = any_o && (win_o == NB_CH'(c));
        end
    end

endmodule

// File: rtl/phase_corrector_scheduler.sv
// Shares one pipelined phase_corrector datapath among N_CH channels,
// with per-channel holding registers and a latency-matched tag pipe.
module phase_corrector_scheduler
    import phase_corrector_pkg::*;
#(
    parameter  int NB_DATA    = NB_DATA_DEF,
    parameter  int N_CH       = N_CH_DEF,
    parameter  int DP_LATENCY = DP_LATENCY_DEF,
    localparam int NB_CH      = $clog2(N_CH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_CH-1:0]         i_ch_en,
    input  logic [N_CH-1:0]         i_valid,
    input  logic [N_CH*NB_DATA-1:0] i_real,
    input  logic [N_CH*NB_DATA-1:0] i_imag,
    output logic [N_CH-1:0]         o_ready,
    output logic [NB_DATA-1:0]      o_dp_real,
    output logic [NB_DATA-1:0]      o_dp_imag,
    output logic                    o_dp_valid,
    input  logic [NB_DATA-1:0]      i_dp_phase,
    output logic [NB_DATA-1:0]      o_phase,
    output logic [N_CH-1:0]         o_valid,
    output logic [NB_CH-1:0]        o_ch,
    output logic                    o_busy
);

    logic [N_CH-1:0]    full_q;
    logic [N_CH-1:0]    full_d;
    logic [N_CH-1:0]    req;
    logic [N_CH-1:0]    gnt;
    logic [N_CH-1:0]    acc;
    logic [NB_DATA-1:0] real_q [N_CH];
    logic [NB_DATA-1:0] imag_q [N_CH];

    logic [NB_CH-1:0]   ptr_q;
    logic [NB_CH-1:0]   win;
    logic               any_gnt;

    logic [NB_DATA-1:0] dp_real_q;
    logic [NB_DATA-1:0] dp_imag_q;
    logic               dp_valid_q;
    logic [NB_CH-1:0]   dp_ch_q;

    tag_t               tag_q [DP_LATENCY];
    tag_t               tag_out;
    logic               tag_busy;
    logic [MAX_CH-1:0]  oh_all;

    logic [NB_DATA-1:0] phase_q;
    logic [N_CH-1:0]    valid_q;
    logic [N_CH-1:0]    valid_d;
    logic [NB_CH-1:0]   ch_q;

    assign req     = full_q & i_ch_en;
    assign o_ready = i_ch_en & ~full_q;
    assign acc     = i_valid & o_ready;
    assign full_d  = (full_q & ~gnt) | acc;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .win_o (win),
        .any_o (any_gnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full_q <= '0;
            for (int c = 0; c < N_CH; c++) begin
                real_q[c] <= '0;
                imag_q[c] <= '0;
            end
        end else begin
            full_q <= full_d;
            for (int c = 0; c < N_CH; c++) begin
                if (acc[c]) begin
                    real_q[c] <= i_real[c*NB_DATA +: NB_DATA];
                    imag_q[c] <= i_imag[c*NB_DATA +: NB_DATA];
                end
            end
        end
    end

    // Idle cycles keep the last issued operands on the datapath bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q      <= NB_CH'(N_CH - 1);
            dp_real_q  <= '0;
            dp_imag_q  <= '0;
            dp_valid_q <= 1'b0;
            dp_ch_q    <= '0;
        end else begin
            dp_valid_q <= any_gnt;
            if (any_gnt) begin
                ptr_q     <= win;
                dp_real_q <= real_q[win];
                dp_imag_q <= imag_q[win];
                dp_ch_q   <= win;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DP_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0].valid <= dp_valid_q;
            tag_q[0].ch    <= CH_W'(dp_ch_q);
            for (int i = 1; i < DP_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tag_out = tag_q[DP_LATENCY-1];
    assign oh_all  = ch_onehot(tag_out.ch);
    assign valid_d = oh_all[N_CH-1:0] & {N_CH{tag_out.valid}};

    if (N_CH < MAX_CH) begin : g_oh_pad
        logic unused_oh;
        assign unused_oh = ^oh_all[MAX_CH-1:N_CH];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase_q <= '0;
            valid_q <= '0;
            ch_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (tag_out.valid) begin
                phase_q <= i_dp_phase;
                ch_q    <= tag_out.ch[NB_CH-1:0];
            end
        end
    end

    always_comb begin
        tag_busy = 1'b0;
        for (int i = 0; i < DP_LATENCY; i++) begin
            tag_busy = tag_busy | tag_q[i].valid;
        end
    end

    assign o_dp_real  = dp_real_q;
    assign o_dp_imag  = dp_imag_q;
    assign o_dp_valid = dp_valid_q;
    assign o_phase    = phase_q;
    assign o_valid    = valid_q;
    assign o_ch       = ch_q;
    assign o_busy     = (|full_q) | tag_busy | dp_valid_q;

endmodule
